// File: rtl/audio_nios_onchip_mem_arbiter_if.sv
// Avalon-MM master-side bundle for one arbiter port: request, write data, stall
// and pipelined read return.
interface audio_nios_onchip_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/audio_nios_onchip_mem_arbiter.sv
// Two-master arbiter (Nios data master = m0, audio DMA = m1) onto the single-port
// on-chip RAM. Round-robin by default; `define ARB_FIXED_PRIO_EN for audio-first priority.
module audio_nios_onchip_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset,

  audio_nios_onchip_mem_arbiter_if.slave m0,
  audio_nios_onchip_mem_arbiter_if.slave m1,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("audio_nios_onchip_mem_arbiter: STARVE_LIMIT must be 1..255");
  end

  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("audio_nios_onchip_mem_arbiter: DATA_W must be a multiple of 8");
  end

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  logic       req0;
  logic       req1;
  logic       gnt0;
  logic       gnt1;
  logic [1:0] rd_owner_q;
  logic [1:0] rd_owner_d;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

`ifdef ARB_FIXED_PRIO_EN
  localparam logic [7:0] STARVE_LIM_B = 8'(STARVE_LIMIT);

  logic [7:0] starve_q;
  logic [7:0] starve_d;
  logic       force0;

  assign force0 = (starve_q >= STARVE_LIM_B);

  always_comb begin
    gnt0 = req0 & (~req1 | force0);
    gnt1 = req1 & ~gnt0;
  end

  // Counts consecutive lost cycles of port 0; saturates so it can never wrap back to 0.
  always_comb begin
    starve_d = starve_q;
    if (!req0 || gnt0) begin
      starve_d = '0;
    end else if (starve_q != '1) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  port_e last_gnt_q;
  port_e last_gnt_d;

  always_comb begin
    gnt0 = req0 & (~req1 | (last_gnt_q == PORT1));
    gnt1 = req1 & ~gnt0;
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt0) begin
      last_gnt_d = PORT0;
    end else if (gnt1) begin
      last_gnt_d = PORT1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= PORT1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  logic                sel_write;
  logic [DATA_W/8-1:0] sel_be;

  // With no grant the mux falls through to port 0; only chipselect/write qualify it.
  always_comb begin
    if (gnt1) begin
      mem_address   = m1.address;
      mem_writedata = m1.writedata;
      sel_write     = m1.write;
      sel_be        = m1.byteenable;
    end else begin
      mem_address   = m0.address;
      mem_writedata = m0.writedata;
      sel_write     = m0.write;
      sel_be        = m0.byteenable;
    end
  end

  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = mem_chipselect & sel_write;
  assign mem_byteenable = sel_write ? sel_be : '1;
  assign mem_clken      = 1'b1;

  assign m0.waitrequest = req0 & ~gnt0;
  assign m1.waitrequest = req1 & ~gnt1;

  // A write wins over a simultaneous read, so only pure reads claim the return slot.
  assign rd_owner_d = {gnt1 & ~m1.write, gnt0 & ~m0.write};

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // Masking with reset drops a read granted the cycle before reset rose.
  assign m0.readdatavalid = rd_owner_q[0] & ~reset;
  assign m1.readdatavalid = rd_owner_q[1] & ~reset;
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;

endmodule
